// File: rtl/jtag_bus_bridge.sv
// rtl/jtag_bus_bridge.sv - JTAG TAP to simple memory-bus bridge
module jtag_bus_bridge #(
   parameter int          ADDR_W  = 8,
   parameter int          DATA_W  = 16,
   parameter logic [31:0] IDCODE  = 32'h1234_5001,
   parameter int          TIMEOUT = 255
) (
   input  logic              tck,
   input  logic              jtag_rst,
   input  logic              tms,
   input  logic              tdi,
   output logic              tdo,
   output logic              enable_tdo,
   input  logic              ready,
   input  logic [DATA_W-1:0] rdata,
   output logic              sel,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata
);

   // One shared DR shift register, wide enough for the largest DR
   localparam int DR_W = (DATA_W + 2 > 32) ? DATA_W + 2 : 32;

   localparam logic [3:0] IR_IDCODE   = 4'b0001;
   localparam logic [3:0] IR_SET_ADDR = 4'b1110;
   localparam logic [3:0] IR_SET_DATA = 4'b1100;
   localparam logic [3:0] IR_DATA_INC = 4'b1000;

   typedef enum logic [3:0] {
      TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR,
      TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR,
      TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
   } tap_state_t;

   typedef enum logic [1:0] {ACC_IDLE, ACC_REQ, ACC_WAIT} acc_state_t;

   tap_state_t        r_tap, w_tap_next;
   acc_state_t        r_acc, w_acc_next;
   logic [3:0]        r_ir, r_ir_sr;
   logic [DR_W-1:0]   r_dr, w_dr_shift, w_dr_cap;
   logic [6:0]        w_dr_len;
   logic              w_sel_idcode, w_sel_addr, w_sel_data;
   logic              w_acc_idle, w_cmd_read, w_cmd_write, w_timeout, w_done;
   logic [1:0]        w_status;
   logic              r_ready_meta, r_ready_s;
   logic              r_we, r_inc, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_data;
   logic [15:0]       r_tmo_cnt;
   logic              r_tdo, r_en;
   logic              w_ir_path;

   assign sel        = (r_acc != ACC_IDLE);
   assign we         = r_we;
   assign addr       = r_addr;
   assign wdata      = r_wdata;
   assign tdo        = r_tdo;
   assign enable_tdo = r_en;
   assign w_acc_idle = (r_acc == ACC_IDLE);

   // TAP state register
   always_ff @(posedge tck) begin
      if (jtag_rst) r_tap <= TAP_TLR;
      else          r_tap <= w_tap_next;
   end

   // TAP next-state decode (IEEE 1149.1 state graph)
   always_comb begin
      w_tap_next = r_tap;
      case (r_tap)
         TAP_TLR:    w_tap_next = tms ? TAP_TLR    : TAP_RTI;
         TAP_RTI:    w_tap_next = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR: w_tap_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR: w_tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_SH_DR:  w_tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_EX1_DR: w_tap_next = tms ? TAP_UPD_DR : TAP_PA_DR;
         TAP_PA_DR:  w_tap_next = tms ? TAP_EX2_DR : TAP_PA_DR;
         TAP_EX2_DR: w_tap_next = tms ? TAP_UPD_DR : TAP_SH_DR;
         TAP_UPD_DR: w_tap_next = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR: w_tap_next = tms ? TAP_TLR    : TAP_CAP_IR;
         TAP_CAP_IR: w_tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_SH_IR:  w_tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_EX1_IR: w_tap_next = tms ? TAP_UPD_IR : TAP_PA_IR;
         TAP_PA_IR:  w_tap_next = tms ? TAP_EX2_IR : TAP_PA_IR;
         TAP_EX2_IR: w_tap_next = tms ? TAP_UPD_IR : TAP_SH_IR;
         TAP_UPD_IR: w_tap_next = tms ? TAP_SEL_DR : TAP_RTI;
         default:    w_tap_next = TAP_TLR;
      endcase
   end

   // Instruction decode; unknown codes fall through to the 1-bit bypass DR
   always_comb begin
      w_sel_idcode = (r_ir == IR_IDCODE);
      w_sel_addr   = (r_ir == IR_SET_ADDR);
      w_sel_data   = (r_ir == IR_SET_DATA) || (r_ir == IR_DATA_INC);
      w_dr_len     = 7'd1;
      if (w_sel_idcode)    w_dr_len = 7'd32;
      else if (w_sel_addr) w_dr_len = 7'(ADDR_W);
      else if (w_sel_data) w_dr_len = 7'(DATA_W + 2);
   end

   // DR shift: tdi enters at the top bit of the currently selected DR length
   always_comb begin
      w_dr_shift = {1'b0, r_dr[DR_W-1:1]};
      for (int i = 0; i < DR_W; i++) begin
         if (i == int'(w_dr_len) - 1) w_dr_shift[i] = tdi;
      end
   end

   // DR capture values; data status reports BUSY first, then a pending timeout
   always_comb begin
      w_dr_cap = '0;
      w_status = 2'b10;
      if (!w_acc_idle) w_status = 2'b01;
      else if (r_err)  w_status = 2'b11;
      if (w_sel_idcode) begin
         w_dr_cap[31:0] = IDCODE;
      end else if (w_sel_addr) begin
         if (w_acc_idle) w_dr_cap[ADDR_W-1:0] = r_addr;
         else            w_dr_cap = r_dr;
      end else if (w_sel_data) begin
         if (w_acc_idle) w_dr_cap[DATA_W+1:2] = r_data;
         w_dr_cap[1:0] = w_status;
      end
   end

   // IR and DR registers, driven by the TAP state
   always_ff @(posedge tck) begin
      if (jtag_rst) begin
         r_ir    <= IR_IDCODE;
         r_ir_sr <= 4'b0;
         r_dr    <= '0;
      end else begin
         case (r_tap)
            TAP_TLR:    r_ir    <= IR_IDCODE;
            TAP_CAP_IR: r_ir_sr <= 4'b0101;
            TAP_SH_IR:  r_ir_sr <= {tdi, r_ir_sr[3:1]};
            TAP_UPD_IR: r_ir    <= r_ir_sr;
            TAP_CAP_DR: r_dr    <= w_dr_cap;
            TAP_SH_DR:  r_dr    <= w_dr_shift;
            default:    ;
         endcase
      end
   end

   // ready crosses from the memory clock domain through two flops
   always_ff @(posedge tck) begin
      if (jtag_rst) begin
         r_ready_meta <= 1'b1;
         r_ready_s    <= 1'b1;
      end else begin
         r_ready_meta <= ready;
         r_ready_s    <= r_ready_meta;
      end
   end

   // Access FSM state register
   always_ff @(posedge tck) begin
      if (jtag_rst) r_acc <= ACC_IDLE;
      else          r_acc <= w_acc_next;
   end

   // Access FSM next state; timeout takes priority over a late ready
   always_comb begin
      w_acc_next  = r_acc;
      w_done      = 1'b0;
      w_cmd_read  = (r_tap == TAP_UPD_DR) && w_sel_data && w_acc_idle && (r_dr[1:0] == 2'b01);
      w_cmd_write = (r_tap == TAP_UPD_DR) && w_sel_data && w_acc_idle && (r_dr[1:0] == 2'b10);
      w_timeout   = !w_acc_idle && (r_tmo_cnt == 16'(TIMEOUT - 1));
      case (r_acc)
         ACC_IDLE: if (w_cmd_read || w_cmd_write) w_acc_next = ACC_REQ;
         ACC_REQ: begin
            if (w_timeout)       w_acc_next = ACC_IDLE;
            else if (!r_ready_s) w_acc_next = ACC_WAIT;
         end
         ACC_WAIT: begin
            if (w_timeout) begin
               w_acc_next = ACC_IDLE;
            end else if (r_ready_s) begin
               w_acc_next = ACC_IDLE;
               w_done     = 1'b1;
            end
         end
         default: w_acc_next = ACC_IDLE;
      endcase
   end

   // Bus-side registers: request fields, read data, address, sticky error
   always_ff @(posedge tck) begin
      if (jtag_rst) begin
         r_we      <= 1'b0;
         r_inc     <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_data    <= '0;
         r_tmo_cnt <= '0;
      end else begin
         if (w_acc_idle) r_tmo_cnt <= '0;
         else            r_tmo_cnt <= r_tmo_cnt + 16'd1;
         if (w_cmd_read || w_cmd_write) begin
            r_we  <= w_cmd_write;
            r_inc <= (r_ir == IR_DATA_INC);
         end
         if (w_cmd_write) begin
            r_wdata <= r_dr[DATA_W+1:2];
            r_data  <= r_dr[DATA_W+1:2];
         end
         if (w_done) begin
            if (!r_we) r_data <= rdata;
            if (r_inc) r_addr <= r_addr + ADDR_W'(1);
         end
         if ((r_tap == TAP_UPD_DR) && w_sel_addr && w_acc_idle) r_addr <= r_dr[ADDR_W-1:0];
         if (w_timeout) r_err <= 1'b1;
         else if ((r_tap == TAP_CAP_DR) && w_sel_data && w_acc_idle) r_err <= 1'b0;
      end
   end

   assign w_ir_path = (r_tap == TAP_SEL_IR) || (r_tap == TAP_CAP_IR) || (r_tap == TAP_SH_IR) ||
                      (r_tap == TAP_EX1_IR) || (r_tap == TAP_PA_IR)  || (r_tap == TAP_EX2_IR) ||
                      (r_tap == TAP_UPD_IR);

   // tdo and its enable change on falling tck so the host samples them on the rising edge
   always_ff @(negedge tck) begin
      if (jtag_rst) begin
         r_tdo <= 1'b0;
         r_en  <= 1'b0;
      end else begin
         r_tdo <= w_ir_path ? r_ir_sr[0] : r_dr[0];
         r_en  <= (r_tap == TAP_SH_DR) || (r_tap == TAP_SH_IR);
      end
   end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// tb/tb_jtag_bus_bridge.sv - directed testbench for jtag_bus_bridge
module tb_jtag_bus_bridge;

   logic        tck = 1'b0;
   logic        jtag_rst, tms, tdi, ready;
   logic [15:0] rdata;
   logic        tdo, enable_tdo, sel, we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        tdo_t, enable_tdo_t, sel_t, we_t;
   logic [7:0]  addr_t;
   logic [15:0] wdata_t;

   int checks = 0;
   int errors = 0;

   logic [63:0] dout, dout_t;
   logic [3:0]  irout;
   logic        en_ok;

   jtag_bus_bridge u_dut (
      .tck(tck), .jtag_rst(jtag_rst), .tms(tms), .tdi(tdi),
      .tdo(tdo), .enable_tdo(enable_tdo), .ready(ready), .rdata(rdata),
      .sel(sel), .we(we), .addr(addr), .wdata(wdata)
   );

   jtag_bus_bridge #(.TIMEOUT(4)) u_dut_t (
      .tck(tck), .jtag_rst(jtag_rst), .tms(tms), .tdi(tdi),
      .tdo(tdo_t), .enable_tdo(enable_tdo_t), .ready(ready), .rdata(rdata),
      .sel(sel_t), .we(we_t), .addr(addr_t), .wdata(wdata_t)
   );

   always #5 tck = ~tck;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clk_bit(input logic t_ms, input logic t_di, output logic o_tdo,
                          output logic o_tdo_t, output logic o_en);
      tms = t_ms;
      tdi = t_di;
      @(posedge tck); #1;
      o_tdo   = tdo;
      o_tdo_t = tdo_t;
      o_en    = enable_tdo;
      @(negedge tck); #1;
   endtask

   task automatic idle(input int n);
      logic a, b, c;
      for (int i = 0; i < n; i++) clk_bit(1'b0, 1'b0, a, b, c);
   endtask

   task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] d,
                           output logic [63:0] d_t, output logic ok);
      logic a, b, c;
      d = '0; d_t = '0; ok = 1'b1;
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
      for (int i = 0; i < n; i++) begin
         clk_bit(i == n - 1, din[i], a, b, c);
         d[i]   = a;
         d_t[i] = b;
         if (c !== 1'b1) ok = 1'b0;
      end
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
   endtask

   task automatic shift_ir(input logic [3:0] ir, output logic [3:0] d);
      logic a, b, c;
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
      for (int i = 0; i < 4; i++) begin
         clk_bit(i == 3, ir[i], a, b, c);
         d[i] = a;
      end
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
   endtask

   task automatic handshake();
      ready = 1'b0;
      idle(3);
      ready = 1'b1;
      idle(4);
   endtask

   task automatic test_reset();
      logic a, b, c;
      jtag_rst = 1'b1;
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b1, 1'b0, a, b, c);
      checks += 6;
      if (sel !== 1'b0)        begin errors++; $display("FAIL reset_sel: got %b expected 0", sel); end
      if (we !== 1'b0)         begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
      if (addr !== 8'h00)      begin errors++; $display("FAIL reset_addr: got %h expected 00", addr); end
      if (wdata !== 16'h0000)  begin errors++; $display("FAIL reset_wdata: got %h expected 0000", wdata); end
      if (tdo !== 1'b0)        begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
      if (enable_tdo !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", enable_tdo); end
      jtag_rst = 1'b0;
      clk_bit(1'b0, 1'b0, a, b, c);
   endtask

   task automatic test_idcode();
      shift_dr(32, 64'h0, dout, dout_t, en_ok);
      checks += 3;
      if (dout[31:0] !== 32'h1234_5001) begin errors++; $display("FAIL idcode: got %h expected 12345001", dout[31:0]); end
      if (en_ok !== 1'b1)     begin errors++; $display("FAIL idcode_en_shift: got %b expected 1", en_ok); end
      if (enable_tdo !== 1'b0) begin errors++; $display("FAIL idcode_en_idle: got %b expected 0", enable_tdo); end
   endtask

   task automatic test_bypass();
      shift_ir(4'b1111, irout);
      checks += 1;
      if (irout !== 4'b0101) begin errors++; $display("FAIL ir_capture: got %b expected 0101", irout); end
      shift_dr(5, 64'b01011, dout, dout_t, en_ok);
      checks += 1;
      if (dout[4:0] !== 5'b10110) begin errors++; $display("FAIL bypass: got %b expected 10110", dout[4:0]); end
      shift_ir(4'b0011, irout);
      shift_dr(5, 64'b01011, dout, dout_t, en_ok);
      checks += 1;
      if (dout[4:0] !== 5'b10110) begin errors++; $display("FAIL unknown_ir_bypass: got %b expected 10110", dout[4:0]); end
   endtask

   task automatic test_write();
      shift_ir(4'b1110, irout);
      shift_dr(8, 64'h3C, dout, dout_t, en_ok);
      checks += 1;
      if (dout[7:0] !== 8'h00) begin errors++; $display("FAIL addr_capture: got %h expected 00", dout[7:0]); end
      shift_ir(4'b1100, irout);
      shift_dr(18, {46'h0, 16'hBEEF, 2'b10}, dout, dout_t, en_ok);
      checks += 4;
      if (sel !== 1'b1)       begin errors++; $display("FAIL wr_sel: got %b expected 1", sel); end
      if (we !== 1'b1)        begin errors++; $display("FAIL wr_we: got %b expected 1", we); end
      if (addr !== 8'h3C)     begin errors++; $display("FAIL wr_addr: got %h expected 3c", addr); end
      if (wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata: got %h expected beef", wdata); end
      idle(5);
      ready = 1'b0;
      idle(3);
      checks += 2;
      if (sel !== 1'b1)       begin errors++; $display("FAIL wr_sel_wait: got %b expected 1", sel); end
      if (wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata_hold: got %h expected beef", wdata); end
      ready = 1'b1;
      idle(4);
      checks += 1;
      if (sel !== 1'b0) begin errors++; $display("FAIL wr_sel_done: got %b expected 0", sel); end
      shift_dr(18, 64'h0, dout, dout_t, en_ok);
      checks += 2;
      if (dout[17:0] !== {16'hBEEF, 2'b10}) begin errors++; $display("FAIL wr_status: got %h expected %h", dout[17:0], {16'hBEEF, 2'b10}); end
      if (addr !== 8'h3C) begin errors++; $display("FAIL wr_no_inc: got %h expected 3c", addr); end
   endtask

   task automatic test_inc();
      shift_ir(4'b1110, irout);
      shift_dr(8, 64'hFF, dout, dout_t, en_ok);
      shift_ir(4'b1000, irout);
      shift_dr(18, {46'h0, 16'h1111, 2'b10}, dout, dout_t, en_ok);
      checks += 2;
      if (sel !== 1'b1)   begin errors++; $display("FAIL inc1_sel: got %b expected 1", sel); end
      if (addr !== 8'hFF) begin errors++; $display("FAIL inc1_addr: got %h expected ff", addr); end
      handshake();
      checks += 2;
      if (sel !== 1'b0)   begin errors++; $display("FAIL inc1_done: got %b expected 0", sel); end
      if (addr !== 8'h00) begin errors++; $display("FAIL inc_wrap: got %h expected 00", addr); end
      shift_dr(18, {46'h0, 16'h2222, 2'b10}, dout, dout_t, en_ok);
      checks += 3;
      if (dout[17:0] !== {16'h1111, 2'b10}) begin errors++; $display("FAIL inc_status: got %h expected %h", dout[17:0], {16'h1111, 2'b10}); end
      if (addr !== 8'h00)     begin errors++; $display("FAIL inc2_addr: got %h expected 00", addr); end
      if (wdata !== 16'h2222) begin errors++; $display("FAIL inc2_wdata: got %h expected 2222", wdata); end
      handshake();
      checks += 1;
      if (addr !== 8'h01) begin errors++; $display("FAIL inc2_next: got %h expected 01", addr); end
   endtask

   task automatic test_read_busy();
      logic a, b, c;
      shift_ir(4'b1110, irout);
      shift_dr(8, 64'h10, dout, dout_t, en_ok);
      checks += 1;
      if (dout[7:0] !== 8'h01) begin errors++; $display("FAIL rd_addr_capture: got %h expected 01", dout[7:0]); end
      shift_ir(4'b1100, irout);
      ready = 1'b0;
      rdata = 16'h0000;
      shift_dr(18, 64'h1, dout, dout_t, en_ok);
      checks += 3;
      if (sel !== 1'b1)   begin errors++; $display("FAIL rd_sel: got %b expected 1", sel); end
      if (we !== 1'b0)    begin errors++; $display("FAIL rd_we: got %b expected 0", we); end
      if (addr !== 8'h10) begin errors++; $display("FAIL rd_addr: got %h expected 10", addr); end
      shift_dr(18, {46'h0, 16'h5555, 2'b10}, dout, dout_t, en_ok);
      checks += 3;
      if (dout[17:0] !== 18'h00001) begin errors++; $display("FAIL rd_busy: got %h expected 00001", dout[17:0]); end
      if (we !== 1'b0)        begin errors++; $display("FAIL rd_ignore_we: got %b expected 0", we); end
      if (wdata !== 16'h2222) begin errors++; $display("FAIL rd_ignore_wdata: got %h expected 2222", wdata); end
      for (int i = 0; i < 5; i++) clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b0, 1'b0, a, b, c);
      checks += 1;
      if (sel !== 1'b1) begin errors++; $display("FAIL tlr_no_abort: got %b expected 1", sel); end
      rdata = 16'h1234;
      ready = 1'b1;
      idle(4);
      checks += 2;
      if (sel !== 1'b0)   begin errors++; $display("FAIL rd_done: got %b expected 0", sel); end
      if (addr !== 8'h10) begin errors++; $display("FAIL rd_no_inc: got %h expected 10", addr); end
      shift_ir(4'b1100, irout);
      shift_dr(18, 64'h0, dout, dout_t, en_ok);
      checks += 1;
      if (dout[17:0] !== {16'h1234, 2'b10}) begin errors++; $display("FAIL rd_data: got %h expected %h", dout[17:0], {16'h1234, 2'b10}); end
   endtask

   task automatic test_timeout();
      logic a, b, c;
      jtag_rst = 1'b1;
      clk_bit(1'b1, 1'b0, a, b, c);
      clk_bit(1'b1, 1'b0, a, b, c);
      jtag_rst = 1'b0;
      ready = 1'b0;
      rdata = 16'hAAAA;
      clk_bit(1'b0, 1'b0, a, b, c);
      shift_ir(4'b1100, irout);
      shift_dr(18, 64'h1, dout, dout_t, en_ok);
      checks += 1;
      if (sel_t !== 1'b1) begin errors++; $display("FAIL tmo_sel_start: got %b expected 1", sel_t); end
      idle(3);
      checks += 1;
      if (sel_t !== 1'b1) begin errors++; $display("FAIL tmo_sel_hold: got %b expected 1", sel_t); end
      idle(1);
      checks += 1;
      if (sel_t !== 1'b0) begin errors++; $display("FAIL tmo_sel_drop: got %b expected 0", sel_t); end
      shift_dr(18, 64'h0, dout, dout_t, en_ok);
      checks += 1;
      if (dout_t[17:0] !== 18'h00003) begin errors++; $display("FAIL tmo_err: got %h expected 00003", dout_t[17:0]); end
      shift_dr(18, 64'h0, dout, dout_t, en_ok);
      checks += 1;
      if (dout_t[17:0] !== 18'h00002) begin errors++; $display("FAIL tmo_err_clear: got %h expected 00002", dout_t[17:0]); end
   endtask

   task automatic test_reset_abort();
      logic a, b, c;
      checks += 1;
      if (sel !== 1'b1) begin errors++; $display("FAIL abort_pre_sel: got %b expected 1", sel); end
      jtag_rst = 1'b1;
      clk_bit(1'b1, 1'b0, a, b, c);
      checks += 2;
      if (sel !== 1'b0) begin errors++; $display("FAIL abort_sel: got %b expected 0", sel); end
      if (we !== 1'b0)  begin errors++; $display("FAIL abort_we: got %b expected 0", we); end
      jtag_rst = 1'b0;
      ready = 1'b1;
      clk_bit(1'b0, 1'b0, a, b, c);
      idle(4);
      shift_ir(4'b1100, irout);
      shift_dr(18, 64'h0, dout, dout_t, en_ok);
      checks += 2;
      if (dout[17:0] !== 18'h00002) begin errors++; $display("FAIL abort_no_capture: got %h expected 00002", dout[17:0]); end
      if (addr !== 8'h00) begin errors++; $display("FAIL abort_addr: got %h expected 00", addr); end
   endtask

   initial begin
      jtag_rst = 1'b1;
      tms      = 1'b1;
      tdi      = 1'b0;
      ready    = 1'b1;
      rdata    = 16'h0000;
      test_reset();
      test_idcode();
      test_bypass();
      test_write();
      test_inc();
      test_read_busy();
      test_timeout();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_bus_bridge.md
JTAG_BUS_BRIDGE -- requirements
Module: jtag_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (1..16).
REQ-002 SHALL have parameter DATA_W, default 16, memory data width (8..32).
REQ-003 SHALL have parameter IDCODE, default 32'h1234_5001, 32-bit device ID (bit 0 = 1).
REQ-004 SHALL have parameter TIMEOUT, default 255, max tck cycles per access (1..65535).
REQ-005 SHALL have one clock and a synchronous active-high reset: tck  in  1  JTAG clock, the only clock.
REQ-006 SHALL have jtag_rst  in  1  synchronous active-high reset, sampled on tck.
REQ-007 SHALL have tms  in  1; tdi  in  1  JTAG mode and serial data in.
REQ-008 SHALL have tdo  out  1; enable_tdo  out  1  serial data out and its drive enable.
REQ-009 SHALL have ready  in  1  memory-controller ready, asynchronous to tck.
REQ-010 SHALL have rdata  in  DATA_W  memory read data, valid while ready is high.
REQ-011 SHALL have sel, we  out  1 each; addr  out  ADDR_W; wdata  out  DATA_W  memory request.

Function
REQ-012 SHALL implement the 16-state IEEE 1149.1 TAP FSM on rising tck; five tms=1 cycles reach Test-Logic-Reset from any state.
REQ-013 SHALL use a 4-bit IR: 1111 BYPASS, 0001 IDCODE, 1110 SET_ADDR, 1100 SET_DATA, 1000 SET_DATA_INC; any other code behaves as BYPASS.
REQ-014 SHALL capture 4'b0101 into the IR shift register in Capture-IR, shift LSB-first in Shift-IR, load IR in Update-IR.
REQ-015 SHALL load IR = IDCODE in Test-Logic-Reset.
REQ-016 SHALL size DRs: BYPASS 1 bit (captures 0); IDCODE 32 bits (captures IDCODE); SET_ADDR ADDR_W bits; SET_DATA/SET_DATA_INC DATA_W+2 bits.
REQ-017 SHALL shift all DRs LSB-first and drive the DR LSB (or IR LSB in IR states) onto tdo, registered on falling tck.
REQ-018 SHALL assert enable_tdo, registered on falling tck, exactly while in Shift-DR or Shift-IR.
REQ-019 SHALL make SET_ADDR capture the current address and, in Update-DR, load the address register, only when the access FSM is IDLE.
REQ-020 SHALL make SET_DATA* capture {data, status}, status[1:0]: 10 OKAY, 01 BUSY, 11 ERR; data is the last read data after a read, last write data after a write, 0 when BUSY.
REQ-021 SHALL decode the Update-DR command from shift bits[1:0]: 01 READ, 10 WRITE, other NOP; bits[DATA_W+1:2] are write data.
REQ-022 SHALL accept a command only when the access FSM is IDLE; commands while busy are ignored with no state change.
REQ-023 SHALL synchronise ready through 2 flops (reset value 1) to produce ready_s.
REQ-024 SHALL implement access FSM IDLE -> REQ (sel=1, we per command, on accepted command) -> WAIT (when ready_s=0) -> IDLE (when ready_s=1, sel=0).
REQ-025 SHALL capture rdata into the read-data register on the WAIT->IDLE transition of a read.
REQ-026 SHALL, in SET_DATA_INC mode, increment the address by 1 modulo 2^ADDR_W on each completed access; addr wraps from all-ones to 0.
REQ-027 SHALL count tck cycles in REQ/WAIT; on reaching TIMEOUT, sel SHALL drop, FSM SHALL return to IDLE, no data is captured, no address increment occurs.
REQ-028 SHALL make a timeout set sticky ERR, reported at the next SET_DATA* capture and then cleared.
REQ-029 SHALL keep addr and wdata constant while sel=1.

Reset
REQ-030 SHALL make jtag_rst=1 at a rising tck force TAP = Test-Logic-Reset, IR = IDCODE, access FSM = IDLE, sel=0, we=0, addr=0, wdata=0, read data=0, ERR=0, timeout counter=0, ready_s=1.
REQ-031 SHALL clear tdo and enable_tdo at the first falling tck while jtag_rst is high.
REQ-032 SHALL abort an in-flight access on reset mid-operation: sel drops next cycle, no increment, no capture.
REQ-033 SHALL NOT abort an in-flight access on TAP Test-Logic-Reset entry via tms.

Verification
REQ-034 SHALL cover: reset, Shift-DR 32 bits -> tdo emits 0x1234_5001 LSB-first.
REQ-035 SHALL cover: IR=BYPASS, shift pattern 1011 -> tdo returns it delayed by one cycle.
REQ-036 SHALL cover: SET_ADDR 0x3C, SET_DATA write 0xBEEF -> sel=1, we=1, addr=0x3C, wdata=0xBEEF until ready handshake; next capture = {0xBEEF, 10}.
REQ-037 SHALL cover: SET_DATA_INC, addr 0xFF, two writes -> addr 0xFF then 0x00.
REQ-038 SHALL cover: issue a read, hold ready low, rescan -> status 01, second command ignored; ready high with rdata 0x1234 -> next capture {0x1234, 10}.
REQ-039 SHALL cover: TIMEOUT=4, ready held low -> sel drops after 4 cycles, next capture status 11, following capture 10.
